// File: rtl/cla_adder.sv
`default_nettype none
// ============================================================================
// Module   : cla_adder
// Purpose  : Registered two-level carry-lookahead adder.
//            {Carry_out, Sum} = A + B + Carry_in, unsigned, modulo 2^WIDTH,
//            loaded on every rising clk edge with a latency of one cycle.
//            Level 1 forms bit generate/propagate and per-group G/P.
//            Level 2 performs lookahead over G/P to get the group carry-ins.
//            Carries inside each group are flat sum-of-products terms based
//            on that group's carry-in, so there is no ripple chain.
// Ports    : clk       - rising-edge clock
//            rst_n     - asynchronous active-low reset (clears outputs)
//            A, B      - WIDTH-bit unsigned addends
//            Carry_in  - carry into bit 0
//            Sum       - registered WIDTH-bit sum
//            Carry_out - registered carry out of bit WIDTH-1
// Revision : 1.0 - initial release
// ============================================================================
module cla_adder #(
    parameter int WIDTH = 2,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Carry_in,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry_out
);

    // Number of lookahead groups. The last group is partial if WIDTH is not
    // a multiple of GROUP.
    localparam int c_ngrp = (WIDTH + GROUP - 1) / GROUP;

    // Generate across bits lo..hi: OR over m of g[m] & p[m+1] & ... & p[hi].
    // The loops scan the full vector with range guards, so every bound is a
    // constant and the result unrolls into a flat sum of products.
    function automatic logic span_gen(input logic [WIDTH-1:0] g,
                                      input logic [WIDTH-1:0] p,
                                      input int lo,
                                      input int hi);
        logic r;
        logic t;
        r = 1'b0;
        for (int m = 0; m < WIDTH; m++) begin
            if (m >= lo && m <= hi) begin
                t = g[m];
                for (int n = 0; n < WIDTH; n++) begin
                    if (n > m && n <= hi) begin
                        t = t & p[n];
                    end
                end
                r = r | t;
            end
        end
        return r;
    endfunction

    // Propagate across bits lo..hi: AND of p[lo..hi].
    function automatic logic span_prop(input logic [WIDTH-1:0] p,
                                       input int lo,
                                       input int hi);
        logic r;
        r = 1'b1;
        for (int n = 0; n < WIDTH; n++) begin
            if (n >= lo && n <= hi) begin
                r = r & p[n];
            end
        end
        return r;
    endfunction

    logic [WIDTH-1:0]  w_g;
    logic [WIDTH-1:0]  w_p;
    logic [c_ngrp-1:0] w_grp_g;
    logic [c_ngrp-1:0] w_grp_p;
    logic [WIDTH-1:0]  w_grp_g_ext;
    logic [WIDTH-1:0]  w_grp_p_ext;
    logic [c_ngrp:0]   w_grp_c;
    logic [WIDTH:0]    w_c;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;

    // Bit-level generate / propagate.
    assign w_g = A & B;
    assign w_p = A ^ B;

    // Group generate / propagate; the last group's upper bound is clipped.
    always_comb begin
        w_grp_g = '0;
        w_grp_p = '0;
        for (int j = 0; j < c_ngrp; j++) begin
            w_grp_g[j] = span_gen(w_g, w_p, j * GROUP,
                                  ((j + 1) * GROUP > WIDTH) ? WIDTH - 1 : (j + 1) * GROUP - 1);
            w_grp_p[j] = span_prop(w_p, j * GROUP,
                                   ((j + 1) * GROUP > WIDTH) ? WIDTH - 1 : (j + 1) * GROUP - 1);
        end
    end

    // Widen G/P to WIDTH so the same span helpers serve the second level
    // (c_ngrp never exceeds WIDTH).
    assign w_grp_g_ext = WIDTH'(w_grp_g);
    assign w_grp_p_ext = WIDTH'(w_grp_p);

    // Second level: carry into group j+1 is the flat lookahead over groups
    // 0..j starting from Carry_in. w_grp_c[c_ngrp] is the adder carry-out.
    always_comb begin
        w_grp_c    = '0;
        w_grp_c[0] = Carry_in;
        for (int j = 0; j < c_ngrp; j++) begin
            w_grp_c[j+1] = span_gen(w_grp_g_ext, w_grp_p_ext, 0, j)
                         | (span_prop(w_grp_p_ext, 0, j) & Carry_in);
        end
    end

    // Bit carries: group boundaries take the second-level carry; all other
    // positions expand from their own group's carry-in.
    always_comb begin
        w_c    = '0;
        w_c[0] = Carry_in;
        for (int i = 1; i < WIDTH; i++) begin
            if ((i % GROUP) == 0) begin
                w_c[i] = w_grp_c[i / GROUP];
            end else begin
                w_c[i] = span_gen(w_g, w_p, (i / GROUP) * GROUP, i - 1)
                       | (span_prop(w_p, (i / GROUP) * GROUP, i - 1) & w_grp_c[i / GROUP]);
            end
        end
        w_c[WIDTH] = w_grp_c[c_ngrp];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= w_p ^ w_c[WIDTH-1:0];
            r_cout <= w_c[WIDTH];
        end
    end

    assign Sum       = r_sum;
    assign Carry_out = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_cla_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_adder
// Purpose  : Self-checking bench for cla_adder. Three instances share clk and
//            rst_n: default (WIDTH=2), WIDTH=8/GROUP=4, and WIDTH=5/GROUP=4
//            (partial last group).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_adder;

    logic       clk;
    logic       rst_n;

    logic [1:0] a2, b2, sum2;
    logic       cin2, cout2;
    logic [7:0] a8, b8, sum8;
    logic       cin8, cout8;
    logic [4:0] a5, b5, sum5;
    logic       cin5, cout5;

    int total;
    int bad;

    cla_adder u_dut2 (
        .clk(clk), .rst_n(rst_n), .A(a2), .B(b2), .Carry_in(cin2),
        .Sum(sum2), .Carry_out(cout2)
    );

    cla_adder #(.WIDTH(8), .GROUP(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Carry_in(cin8),
        .Sum(sum8), .Carry_out(cout8)
    );

    cla_adder #(.WIDTH(5), .GROUP(4)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .A(a5), .B(b5), .Carry_in(cin5),
        .Sum(sum5), .Carry_out(cout5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait for the next rising edge, then step 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a2 = 2'b11; b2 = 2'b11; cin2 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        a5 = 5'h1F; b5 = 5'h1F; cin5 = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (sum2 !== 2'b00 || cout2 !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold2 cyc=%0d got sum=%b cout=%b want sum=00 cout=0", k, sum2, cout2);
            end
            total++;
            if (sum8 !== 8'h00 || cout8 !== 1'b0 || sum5 !== 5'h00 || cout5 !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold_wide cyc=%0d got sum8=%h cout8=%b sum5=%h cout5=%b want all 0",
                         k, sum8, cout8, sum5, cout5);
            end
            step();
        end
        rst_n = 1'b1;
        step();
        // 3 + 3 + 1 = 7 -> sum 11, carry 1
        total++;
        if (sum2 !== 2'b11 || cout2 !== 1'b1) begin
            bad++;
            $display("FAIL reset_release got sum=%b cout=%b want sum=11 cout=1", sum2, cout2);
        end
    endtask

    task automatic test_sweep(input logic cin);
        logic [2:0] exp3;
        logic [1:0] av, bv;
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                av = 2'(a);
                bv = 2'(b);
                a2 = av; b2 = bv; cin2 = cin;
                exp3 = 3'(a + b) + {2'b00, cin};
                step();
                total++;
                if (sum2 !== exp3[1:0] || cout2 !== exp3[2]) begin
                    bad++;
                    $display("FAIL sweep cin=%b a=%b b=%b got sum=%b cout=%b want sum=%b cout=%b",
                             cin, av, bv, sum2, cout2, exp3[1:0], exp3[2]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        a2 = 2'b10; b2 = 2'b11; cin2 = 1'b0;
        step();
        // 2 + 3 = 5 -> sum 01, carry 1
        total++;
        if (sum2 !== 2'b01 || cout2 !== 1'b1) begin
            bad++;
            $display("FAIL async_pre got sum=%b cout=%b want sum=01 cout=1", sum2, cout2);
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (sum2 !== 2'b00 || cout2 !== 1'b0) begin
            bad++;
            $display("FAIL async_clear got sum=%b cout=%b want sum=00 cout=0", sum2, cout2);
        end
        step();
        total++;
        if (sum2 !== 2'b00 || cout2 !== 1'b0) begin
            bad++;
            $display("FAIL async_hold got sum=%b cout=%b want sum=00 cout=0", sum2, cout2);
        end
        rst_n = 1'b1;
        #2;
        total++;
        if (sum2 !== 2'b00 || cout2 !== 1'b0) begin
            bad++;
            $display("FAIL async_release_noedge got sum=%b cout=%b want sum=00 cout=0", sum2, cout2);
        end
        step();
        total++;
        if (sum2 !== 2'b01 || cout2 !== 1'b1) begin
            bad++;
            $display("FAIL async_first_edge got sum=%b cout=%b want sum=01 cout=1", sum2, cout2);
        end
    endtask

    task automatic test_wide8();
        logic [7:0] va [4] = '{8'hFF, 8'h0F, 8'hFF, 8'hA5};
        logic [7:0] vb [4] = '{8'h00, 8'h01, 8'hFF, 8'h5A};
        logic       vc [4] = '{1'b1,  1'b0,  1'b1,  1'b0};
        logic [7:0] es [4] = '{8'h00, 8'h10, 8'hFF, 8'hFF};
        logic       ec [4] = '{1'b1,  1'b0,  1'b1,  1'b0};
        for (int k = 0; k < 4; k++) begin
            a8 = va[k]; b8 = vb[k]; cin8 = vc[k];
            step();
            total++;
            if (sum8 !== es[k] || cout8 !== ec[k]) begin
                bad++;
                $display("FAIL wide8 vec=%0d got sum=%h cout=%b want sum=%h cout=%b",
                         k, sum8, cout8, es[k], ec[k]);
            end
        end
    endtask

    task automatic test_partial5();
        logic [5:0] exp6;
        a5 = 5'h1F; b5 = 5'h01; cin5 = 1'b0;
        step();
        total++;
        if (sum5 !== 5'h00 || cout5 !== 1'b1) begin
            bad++;
            $display("FAIL partial5_wrap got sum=%h cout=%b want sum=00 cout=1", sum5, cout5);
        end
        a5 = 5'h0F; b5 = 5'h00; cin5 = 1'b1;
        step();
        total++;
        if (sum5 !== 5'h10 || cout5 !== 1'b0) begin
            bad++;
            $display("FAIL partial5_boundary got sum=%h cout=%b want sum=10 cout=0", sum5, cout5);
        end
        for (int k = 0; k < 1000; k++) begin
            a5   = 5'($urandom_range(31, 0));
            b5   = 5'($urandom_range(31, 0));
            cin5 = 1'($urandom_range(1, 0));
            exp6 = {1'b0, a5} + {1'b0, b5} + {5'b0, cin5};
            step();
            total++;
            if (sum5 !== exp6[4:0] || cout5 !== exp6[5]) begin
                bad++;
                $display("FAIL partial5_rand k=%0d a=%h b=%h cin=%b got sum=%h cout=%b want sum=%h cout=%b",
                         k, a5, b5, cin5, sum5, cout5, exp6[4:0], exp6[5]);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        a2 = '0; b2 = '0; cin2 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0;
        a5 = '0; b5 = '0; cin5 = 1'b0;
        #1;
        test_reset();
        test_sweep(1'b1);
        test_sweep(1'b0);
        test_async_reset();
        test_wide8();
        test_partial5();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cla_adder.md
Name: cla_adder

Overview:
Parameterised carry-lookahead adder computing {Carry_out, Sum} = A + B + Carry_in, with the result registered on the clock. Carries come from two-level lookahead (bit-level generate/propagate, then group lookahead), with no ripple chain. It is intended as a reusable arithmetic leaf inside datapath blocks. The default configuration is 2 bits wide.

Parameters:
WIDTH, 2, operand and sum width in bits; must be at least 1.
GROUP, 4, bits per lookahead group; the last group is partial when WIDTH is not a multiple of GROUP.

Ports:
clk  input  1  system clock; rising edge active
rst_n  input  1  asynchronous active-low reset
A  input  WIDTH  addend, unsigned
B  input  WIDTH  addend, unsigned
Carry_in  input  1  carry into bit 0
Sum  output  WIDTH  registered sum bits [WIDTH-1:0]
Carry_out  output  1  registered carry out of bit WIDTH-1

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset:
  - rst_n low forces Sum = 0 and Carry_out = 0 immediately, independent of clk.
  - Outputs hold 0 while rst_n stays low.
  - On deassertion, the first rising clk edge with rst_n high captures a result.
- Latency:
  - Exactly 1 cycle.
  - At each rising clk edge, Sum/Carry_out load the combinational result of the A, B, Carry_in values present just before that edge.
  - No input registers; inputs need only meet setup time at the edge.
  - Full throughput: a new operand set can be applied every cycle.
- Bit level: g[i] = A[i] & B[i]; p[i] = A[i] ^ B[i].
- Group level, per group j:
  - Group generate G[j] and group propagate P[j] are formed from the bit g/p by lookahead expressions.
  - Carries inside a group are c[k+1] = g[k] | p[k]&c[k], expanded in flat sum-of-products form relative to the group carry-in.
- Second level: group carry-ins come from lookahead over G/P, starting from Carry_in.
- Output logic: Sum[i] = p[i] ^ c[i], with c[0] = Carry_in. Carry_out = c[WIDTH].
- Arithmetic:
  - Unsigned, modulo 2^WIDTH.
  - Carry_out is 1 exactly when A + B + Carry_in >= 2^WIDTH.
  - No overflow flag and no signed interpretation.
- Boundaries:
  - All-ones + all-ones + 1 gives Sum = all-ones, Carry_out = 1.
  - All-ones + 0 + 1 wraps to Sum = 0, Carry_out = 1.
  - A WIDTH smaller than GROUP gives a single partial group, which must still be correct.
- Reset mid-operation: the in-flight result is discarded and outputs go to 0 asynchronously. No state survives reset.
- No X propagation from reset: all flops are reset.

Test Plan:
- Reset: hold rst_n=0 with A=2'b11, B=2'b11, Carry_in=1 and toggle clk -> Sum=2'b00 and Carry_out=0 throughout. Release reset -> the next edge gives Sum=2'b11, Carry_out=1.
- Exhaustive WIDTH=2 sweep with Carry_in=1, applying all 16 A/B pairs one per cycle. Each result appears one edge later; for example A=00,B=00 -> Sum=01,Cout=0; A=01,B=10 -> Sum=00,Cout=1; A=10,B=01 -> Sum=00,Cout=1; A=11,B=11 -> Sum=11,Cout=1.
- Same sweep with Carry_in=0 -> for example A=01,B=01 -> Sum=10,Cout=0; A=11,B=01 -> Sum=00,Cout=1. All 16 results must match A+B modulo 4, with the carry correct.
- Asynchronous reset mid-stream: assert rst_n low between edges while A=2'b10, B=2'b11 -> outputs go to 0 before the next edge with no clk needed. They stay 0 until the first edge after release.
- WIDTH=8, GROUP=4 -> 8'hFF+8'h00+1 gives Sum=8'h00,Cout=1; 8'h0F+8'h01+0 gives Sum=8'h10,Cout=0; 8'hFF+8'hFF+1 gives Sum=8'hFF,Cout=1.
- WIDTH=5, GROUP=4 (partial group) -> 5'h1F+5'h01+0 gives Sum=5'h00,Cout=1. A random 1000-vector compare against a reference model must pass.
